sd_image_arbiter: RTL and testbench
===================================

Name: sd_image_arbiter

Overview:
- Parametrised N-channel arbiter for user_io's single SD sector interface.
- Generalises the fixed sd_lba/sd_ack/sd_buff_din muxing used at machine top level; adds round-robin arbitration, transfer ownership tracking and per-channel ack routing.
- Sits between the core's disk/tape controllers (floppy, DDP tape, ...) and user_io.

Parameters:
- NUM_CH, 4, number of requesting image channels (1..8); also user_io SD_IMAGES.
- LBA_W, 32, sector address width.
- TIMEOUT_CYC, 24'd12_000_000, cycles to wait for host_ack (used only with SD_ARB_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ch_rd  in  NUM_CH  per-channel sector read request; held until own ch_ack rises.
- ch_wr  in  NUM_CH  per-channel sector write request; same rule.
- ch_lba  in  NUM_CH*LBA_W  per-channel LBA; channel i at [i*LBA_W +: LBA_W].
- ch_buff_din  in  NUM_CH*8  per-channel write data; channel i at [i*8 +: 8].
- ch_ack  out  NUM_CH  per-channel ack, one-hot or zero.
- host_rd  out  NUM_CH  to user_io sd_rd, one-hot.
- host_wr  out  NUM_CH  to user_io sd_wr, one-hot.
- host_lba  out  LBA_W  to user_io sd_lba.
- host_ack  in  1  from user_io sd_ack.
- host_buff_din  out  8  to user_io sd_din.
- grant_idx  out  $clog2(NUM_CH) (min 1)  channel currently owning the interface.
- busy  out  1  high in REQ or XFER.
- timeout_err  out  1  one-cycle pulse on request timeout.

Behaviour:
- Reset values: state IDLE; host_rd, host_wr, host_lba, grant_idx, rr_ptr, timeout_err = 0; busy = 0.
- Reset acts on the next edge even mid-transfer; ch_ack is forced 0 while in IDLE.
- req[i] = ch_rd[i] | ch_wr[i].
- IDLE:
  - Grants only when host_ack == 0 and |req. This blocks a new grant while a transfer interrupted by reset is still draining.
  - Winner is the first set req index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CH.
  - On the grant edge, register: grant_idx = winner; op = rd if ch_rd[winner] else wr (rd wins when both are set; wr stays pending); host_lba = ch_lba[winner].
  - Set host_rd[winner] or host_wr[winner] (registered, 1 cycle after req sampled). Go to REQ.
- REQ:
  - Hold host_rd/host_wr and host_lba stable.
  - On host_ack == 1: clear host_rd/host_wr on that edge and go to XFER.
  - A channel dropping its request in REQ does not cancel; the host request stays until ack. Data for the withdrawn request is discarded by the requester.
- XFER:
  - Stay while host_ack == 1.
  - On host_ack == 0: go to IDLE; rr_ptr = (grant_idx + 1) mod NUM_CH.
- ch_ack[i] = host_ack & (state != IDLE) & (grant_idx == i). Combinational, zero latency, aligned with user_io sd_buff_addr/sd_dout_strobe, which are broadcast to all channels.
- host_buff_din = ch_buff_din[grant_idx], combinational. Value in IDLE is don't-care but must be deterministic.
- busy = (state == REQ) | (state == XFER).
- Minimum gap between transfers: one IDLE cycle after ack falls.
- NUM_CH == 1: arbitration degenerates, grant_idx is constant 0, and behaviour is otherwise identical.
- Indices >= NUM_CH are never granted; rr_ptr wraps at NUM_CH-1 -> 0, not at the power of two.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT_CYC-1 with no host_ack: clear host_rd/host_wr, pulse timeout_err for 1 cycle, and go to IDLE.
  - rr_ptr advances; ch_ack is never asserted for that request.
  - A requester still holding its request is re-arbitrated normally.
- Without the macro: no counter; REQ waits indefinitely; timeout_err is tied 0. The port exists in both builds.

Test Plan:
- NUM_CH=4, ch_rd[2]=1, ch_lba[2]=0x1234, host_ack high 5 cycles after host_rd -> host_rd=4'b0100 one cycle after request; host_lba=0x1234; ch_ack=4'b0100 exactly while host_ack high; busy falls and rr_ptr=3 after ack drops.
- ch_rd[0] and ch_rd[3] raised together, rr_ptr=0 -> channel 0 served first, channel 3 second with one IDLE cycle between. Then ch_rd[0] and ch_rd[1] raised with rr_ptr=0 after channel 3 -> channel 0 first.
- ch_rd[1]=ch_wr[1]=1 -> host_rd=4'b0010 first; host_wr=4'b0010 granted on the following arbitration.
- Write on ch 3 with ch_buff_din[3]=0xA5, others 0x00 -> host_buff_din=0xA5 throughout XFER.
- Reset asserted mid-XFER with host_ack held high 10 more cycles, ch_rd[0] pending -> all outputs 0 next edge; no grant until host_ack falls; then host_rd=4'b0001.
- SD_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, ch_rd[1] with host_ack never asserted -> host_rd[1] high 16 cycles; timeout_err pulses once; ch_ack stays 0; ch_rd[1] re-granted after one IDLE cycle.

Source files
------------

// File: rtl/sd_image_arbiter.sv
// sd_image_arbiter
// Round-robin arbiter that shares user_io's single SD sector interface
// between NUM_CH image channels (floppy, tape, ...). It tracks which channel
// owns the current transfer and routes the host ack back to that channel only.
//
// Optional feature: define SD_ARB_TIMEOUT_EN to abandon a host request that
// sees no host_ack within TIMEOUT_CYC cycles. When it is undefined, REQ waits
// indefinitely and timeout_err is constant 0.
//
// Ports:
//   clk_sys        system clock, rising edge
//   reset          synchronous, active-high
//   ch_rd/ch_wr    per-channel sector read/write requests
//   ch_lba         per-channel LBA, channel i at [i*LBA_W +: LBA_W]
//   ch_buff_din    per-channel write data, channel i at [i*8 +: 8]
//   ch_ack         per-channel ack (combinational, one-hot or zero)
//   host_rd/wr     one-hot request to user_io sd_rd/sd_wr
//   host_lba       sector address to user_io sd_lba
//   host_ack       user_io sd_ack
//   host_buff_din  write data of the owning channel (combinational)
//   grant_idx      channel currently owning the interface
//   busy           high while a request or transfer is in progress
//   timeout_err    one-cycle pulse when a request is abandoned
module sd_image_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned LBA_W       = 32,
    parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000,
    localparam int unsigned IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_rd,
    input  logic [NUM_CH-1:0]       ch_wr,
    input  logic [NUM_CH*LBA_W-1:0] ch_lba,
    input  logic [NUM_CH*8-1:0]     ch_buff_din,
    output logic [NUM_CH-1:0]       ch_ack,
    output logic [NUM_CH-1:0]       host_rd,
    output logic [NUM_CH-1:0]       host_wr,
    output logic [LBA_W-1:0]        host_lba,
    input  logic                    host_ack,
    output logic [7:0]              host_buff_din,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [NUM_CH-1:0]  r_host_rd,     w_host_rd_nxt;
    logic [NUM_CH-1:0]  r_host_wr,     w_host_wr_nxt;
    logic [LBA_W-1:0]   r_host_lba,    w_host_lba_nxt;
    logic [IDX_W-1:0]   r_grant_idx,   w_grant_idx_nxt;
    logic [IDX_W-1:0]   r_rr_ptr,      w_rr_ptr_nxt;
    logic               r_busy;
    logic               r_timeout_err, w_timeout_err_nxt;

    logic [NUM_CH-1:0]  w_req;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_scan_idx;
    logic [IDX_W-1:0]   w_rr_after;

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0]        r_tmo_cnt,     w_tmo_cnt_nxt;
`else
    logic               w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYC;
`endif

    assign w_req = ch_rd | ch_wr;

    // Round-robin scan: first requester at or after rr_ptr, wrapping at NUM_CH
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_scan_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan_idx = IDX_W'((32'(r_rr_ptr) + 32'(k)) % NUM_CH);
            if (!w_found && w_req[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    // Next round-robin start is the channel after the one just served
    assign w_rr_after = IDX_W'((32'(r_grant_idx) + 32'd1) % NUM_CH);

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_host_rd_nxt     = r_host_rd;
        w_host_wr_nxt     = r_host_wr;
        w_host_lba_nxt    = r_host_lba;
        w_grant_idx_nxt   = r_grant_idx;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_timeout_err_nxt = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        w_tmo_cnt_nxt     = r_tmo_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                // A lingering host_ack (transfer cut short by reset) blocks new grants
                if (!host_ack && w_found) begin
                    w_state_nxt     = S_REQ;
                    w_grant_idx_nxt = w_winner;
                    w_host_lba_nxt  = ch_lba[32'(w_winner)*LBA_W +: LBA_W];
                    w_host_rd_nxt   = '0;
                    w_host_wr_nxt   = '0;
                    // Read wins over write; the write stays pending for a later grant
                    if (ch_rd[w_winner]) begin
                        w_host_rd_nxt[w_winner] = 1'b1;
                    end else begin
                        w_host_wr_nxt[w_winner] = 1'b1;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    w_tmo_cnt_nxt   = '0;
`endif
                end
            end
            S_REQ: begin
                if (host_ack) begin
                    w_state_nxt   = S_XFER;
                    w_host_rd_nxt = '0;
                    w_host_wr_nxt = '0;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TIMEOUT_CYC - 24'd1) begin
                    w_state_nxt       = S_IDLE;
                    w_host_rd_nxt     = '0;
                    w_host_wr_nxt     = '0;
                    w_timeout_err_nxt = 1'b1;
                    w_rr_ptr_nxt      = w_rr_after;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 24'd1;
                end
`endif
            end
            S_XFER: begin
                if (!host_ack) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = w_rr_after;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_host_rd_nxt = '0;
                w_host_wr_nxt = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_host_rd     <= '0;
            r_host_wr     <= '0;
            r_host_lba    <= '0;
            r_grant_idx   <= '0;
            r_rr_ptr      <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            r_tmo_cnt     <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_host_rd     <= w_host_rd_nxt;
            r_host_wr     <= w_host_wr_nxt;
            r_host_lba    <= w_host_lba_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_timeout_err <= w_timeout_err_nxt;
`ifdef SD_ARB_TIMEOUT_EN
            r_tmo_cnt     <= w_tmo_cnt_nxt;
`endif
        end
    end

    // Ack routed to the owner only; zero-latency so it lines up with user_io strobes
    always_comb begin
        ch_ack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = host_ack && (r_state != S_IDLE) && (r_grant_idx == IDX_W'(i));
        end
    end

    // Write data follows the last granted channel, so it is deterministic in IDLE too
    assign host_buff_din = ch_buff_din[32'(r_grant_idx)*8 +: 8];

    assign host_rd     = r_host_rd;
    assign host_wr     = r_host_wr;
    assign host_lba    = r_host_lba;
    assign grant_idx   = r_grant_idx;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sd_image_arbiter.sv
// Directed bench for sd_image_arbiter with NUM_CH=4: a per-cycle vector table
// plus a hand-written sequence for the request timeout (or its absence).
module tb_sd_image_arbiter;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned LBA_W  = 32;

    logic                    clk_sys = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       ch_rd;
    logic [NUM_CH-1:0]       ch_wr;
    logic [NUM_CH*LBA_W-1:0] ch_lba;
    logic [NUM_CH*8-1:0]     ch_buff_din;
    logic [NUM_CH-1:0]       ch_ack;
    logic [NUM_CH-1:0]       host_rd;
    logic [NUM_CH-1:0]       host_wr;
    logic [LBA_W-1:0]        host_lba;
    logic                    host_ack;
    logic [7:0]              host_buff_din;
    logic [1:0]              grant_idx;
    logic                    busy;
    logic                    timeout_err;

    sd_image_arbiter #(
        .NUM_CH      (NUM_CH),
        .LBA_W       (LBA_W),
        .TIMEOUT_CYC (24'd16)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ch_rd         (ch_rd),
        .ch_wr         (ch_wr),
        .ch_lba        (ch_lba),
        .ch_buff_din   (ch_buff_din),
        .ch_ack        (ch_ack),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_lba      (host_lba),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        rst;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        ack;
        logic [3:0]  e_rd;
        logic [3:0]  e_wr;
        logic [3:0]  e_ack;
        logic        e_busy;
        logic [1:0]  e_g;
        logic [31:0] e_lba;
    } vec_t;

    vec_t       tv[$];
    logic [7:0] buf_tab [4];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic void add(input logic rst, input logic [3:0] rd, input logic [3:0] wr,
                                input logic ack, input logic [3:0] e_rd, input logic [3:0] e_wr,
                                input logic [3:0] e_ack, input logic e_busy, input logic [1:0] e_g,
                                input logic [31:0] e_lba);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.ack = ack;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_ack = e_ack;
        v.e_busy = e_busy; v.e_g = e_g; v.e_lba = e_lba;
        tv.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        ch_lba      = {32'h0000_1003, 32'h0000_1234, 32'h0000_1001, 32'h0000_1000};
        ch_buff_din = {8'hA5, 8'h33, 8'h22, 8'h11};
        buf_tab     = '{8'h11, 8'h22, 8'h33, 8'hA5};

        //   rst rd       wr       ack  e_rd     e_wr     e_ack    bsy g  lba
        // Single read on channel 2
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 32'h1234);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 32'h1234);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 32'h1234);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 32'h1234);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 32'h1234);
        add(0, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100, 1, 2, 32'h1234);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100, 1, 2, 32'h1234);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100, 1, 2, 32'h1234);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 32'h1234);
        // Reset to bring rr_ptr back to 0
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0000);
        // Channels 0 and 3 together: 0 first, 3 after one IDLE cycle
        add(0, 4'b1001, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 32'h1000);
        add(0, 4'b1001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 32'h1000);
        add(0, 4'b1000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 32'h1000);
        add(0, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h1000);
        add(0, 4'b1000, 4'b0000, 0, 4'b1000, 4'b0000, 4'b0000, 1, 3, 32'h1003);
        add(0, 4'b1000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b1000, 1, 3, 32'h1003);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 3, 32'h1003);
        // rr_ptr wrapped 3 -> 0: channels 0 and 1, channel 0 first
        add(0, 4'b0011, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 32'h1000);
        add(0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 32'h1000);
        add(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h1000);
        add(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 32'h1001);
        add(0, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 32'h1001);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 32'h1001);
        // Read and write both on channel 1: read first, write next
        add(0, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 32'h1001);
        add(0, 4'b0010, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 32'h1001);
        add(0, 4'b0000, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 32'h1001);
        add(0, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 32'h1001);
        add(0, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0000, 1, 1, 32'h1001);
        add(0, 4'b0000, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 32'h1001);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 32'h1001);
        // Write on channel 3, data 0xA5 through XFER
        add(0, 4'b0000, 4'b1000, 0, 4'b0000, 4'b1000, 4'b0000, 1, 3, 32'h1003);
        add(0, 4'b0000, 4'b1000, 1, 4'b0000, 4'b0000, 4'b1000, 1, 3, 32'h1003);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b1000, 1, 3, 32'h1003);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b1000, 1, 3, 32'h1003);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 3, 32'h1003);
        // Reset mid-XFER with host_ack still high: no grant until it falls
        add(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 32'h1000);
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 32'h1000);
        add(1, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0000);
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0000);
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0000);
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0000);
        add(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 32'h1000);
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 32'h1000);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h1000);
        // Request withdrawn in REQ: host request holds until ack
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 32'h1234);
        add(0, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 32'h1234);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100, 1, 2, 32'h1234);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 32'h1234);
        // rr_ptr=3 with channels 0,1 requesting: scan wraps to 0
        add(0, 4'b0011, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 32'h1000);
        add(0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 32'h1000);
        add(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h1000);
        add(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 32'h1001);
        add(0, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 32'h1001);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 32'h1001);

        // Reset state
        reset    = 1'b1;
        ch_rd    = '0;
        ch_wr    = '0;
        host_ack = 1'b0;
        tick();
        tick();
        chk("rst_host_rd", -1, 32'(host_rd), 32'h0);
        chk("rst_host_wr", -1, 32'(host_wr), 32'h0);
        chk("rst_host_lba", -1, host_lba, 32'h0);
        chk("rst_grant_idx", -1, 32'(grant_idx), 32'h0);
        chk("rst_busy", -1, 32'(busy), 32'h0);
        chk("rst_timeout_err", -1, 32'(timeout_err), 32'h0);
        chk("rst_ch_ack", -1, 32'(ch_ack), 32'h0);

        // Table: inputs held across the edge, outputs sampled 1 ns after it
        foreach (tv[i]) begin
            reset    = tv[i].rst;
            ch_rd    = tv[i].rd;
            ch_wr    = tv[i].wr;
            host_ack = tv[i].ack;
            tick();
            chk("host_rd", i, 32'(host_rd), 32'(tv[i].e_rd));
            chk("host_wr", i, 32'(host_wr), 32'(tv[i].e_wr));
            chk("ch_ack", i, 32'(ch_ack), 32'(tv[i].e_ack));
            chk("busy", i, 32'(busy), 32'(tv[i].e_busy));
            chk("grant_idx", i, 32'(grant_idx), 32'(tv[i].e_g));
            chk("host_lba", i, host_lba, tv[i].e_lba);
            chk("host_buff_din", i, 32'(host_buff_din), 32'(buf_tab[tv[i].e_g]));
            chk("timeout_err", i, 32'(timeout_err), 32'h0);
        end

        // Hand-written: request on channel 1 that host never acks
        reset    = 1'b1;
        ch_rd    = '0;
        ch_wr    = '0;
        host_ack = 1'b0;
        tick();
        reset = 1'b0;
        ch_rd = 4'b0010;
`ifdef SD_ARB_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("tmo_host_rd_held", 100 + c, 32'(host_rd), 32'h2);
            chk("tmo_no_pulse_yet", 100 + c, 32'(timeout_err), 32'h0);
            chk("tmo_ch_ack", 100 + c, 32'(ch_ack), 32'h0);
        end
        tick();
        chk("tmo_host_rd_clear", 200, 32'(host_rd), 32'h0);
        chk("tmo_pulse", 200, 32'(timeout_err), 32'h1);
        chk("tmo_busy_idle", 200, 32'(busy), 32'h0);
        chk("tmo_ch_ack_idle", 200, 32'(ch_ack), 32'h0);
        tick();
        chk("tmo_regrant_rd", 201, 32'(host_rd), 32'h2);
        chk("tmo_pulse_once", 201, 32'(timeout_err), 32'h0);
        chk("tmo_regrant_busy", 201, 32'(busy), 32'h1);
        chk("tmo_regrant_idx", 201, 32'(grant_idx), 32'h1);
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("wait_host_rd_held", 100 + c, 32'(host_rd), 32'h2);
            chk("wait_no_timeout", 100 + c, 32'(timeout_err), 32'h0);
        end
        host_ack = 1'b1;
        tick();
        chk("wait_late_ack", 200, 32'(ch_ack), 32'h2);
        chk("wait_late_rd_clear", 200, 32'(host_rd), 32'h0);
        ch_rd    = '0;
        host_ack = 1'b0;
        tick();
        chk("wait_done_busy", 201, 32'(busy), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
